uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller between the oversampling UART receiver and the bus.
//  - Captures each byte on the receiver's done pulse into a first-word-fall-through (FWFT) FIFO.
//  - Presents bytes downstream on a valid/ready handshake.
//  - Keeps sticky overflow and framing-error flags.
//  - Raises a character-timeout pulse when bytes sit unread while the line has gone quiet.
// PARAMETERS
//  Depth        16  FIFO entries; power of two, >= 2
//  Oversample   16  receiver clocks per bit; must match the receiver
//  TimeoutChars 4   idle character times (10 bits each) before timeout fires
// PORTS
//  clk         in   1                 system clock, rising edge
//  reset       in   1                 synchronous, active-high reset
//  rxData      in   8                 receiver data byte; valid when rxDone=1
//  rxDone      in   1                 receiver byte-complete strobe, 1 cycle
//  rxErr       in   1                 receiver framing/sync error strobe, 1 cycle
//  enable      in   1                 1 = accept bytes; 0 = discard incoming bytes
//  outData     out  8                 FIFO head byte
//  outValid    out  1                 FIFO non-empty
//  outReady    in   1                 consumer accepts head when outValid & outReady
//  count       out  $clog2(Depth)+1   current fill level, 0..Depth
//  overflow    out  1                 sticky: a byte was dropped because the FIFO was full
//  framingErr  out  1                 sticky: rxErr was seen
//  clearFlags  in   1                 clears overflow and framingErr
//  timeout     out  1                 character-timeout pulse, 1 cycle
//  errCount    out  8                 only present with UART_RX_ERRCNT_EN
// BEHAVIOUR
//  Reset: the following are all 0 and stay 0 through the reset cycle:
//   count, pointers, outValid, overflow, framingErr, timeout, errCount, timeout FSM state, idle counter.
//   outData is don't-care while outValid=0.
//  Push: rxDone & enable & ~rxErr at edge N -> byte stored; outValid=1 from cycle N+1 if it was empty.
//  Pop: outValid & outReady at an edge -> head retired; the next entry appears on outData the following cycle.
//  outData is driven from the memory at the read pointer (FWFT); no extra read latency.
//  Pointers: width $clog2(Depth) and wrap naturally. count is tracked separately:
//   +1 on push only, -1 on pop only, unchanged on push+pop.
//  Full (count==Depth) with push and no pop -> byte dropped, overflow set, count unchanged.
//  Full with simultaneous push and pop -> both happen; no overflow.
//  Empty: a pop request is impossible, since outValid=0. outReady is ignored.
//  rxErr=1: framingErr set. If rxDone is also 1 in that cycle, the byte is discarded.
//  enable=0: bytes are discarded without setting overflow. FIFO continues to drain. Flags still update.
//  clearFlags: clears both sticky flags. A set event in the same cycle wins, so the flag stays 1.
//  Timeout FSM, idle threshold T = TimeoutChars*10*Oversample cycles:
//   IDLE  : count==0. Idle counter held at 0. Go ARMED on the first push.
//   ARMED : idle counter +1 per cycle.
//           - Any push resets the counter to 0.
//           - count reaching 0 -> IDLE.
//           - counter==T-1 with count!=0 -> assert timeout for exactly 1 cycle, then go FIRED.
//   FIRED : no further pulses.
//           - A push -> ARMED with counter 0.
//           - count reaching 0 -> IDLE.
//  Pops do not reset the idle counter; only receive activity does.
//  Reset mid-operation: FIFO contents are lost, all state returns to the reset values, and the next byte is stored at entry 0.
// CONFIGURATION
//  UART_RX_ERRCNT_EN defined:
//   errCount port exists. It counts rxErr strobes plus dropped-on-full bytes and saturates at 255.
//   clearFlags zeroes it; an increment in the same cycle wins and yields 1.
//  Not defined: port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset, then push 0xA5 at cycle 5, outReady=0 -> outValid=1 and outData=0xA5 at cycle 6, count=1.
//  2. Push 16 bytes 0x00..0x0F, then a 17th byte 0xFF -> count=16 and overflow=1;
//     draining returns 0x00..0x0F in order and 0xFF never appears.
//  3. FIFO full, push 0x55 while popping -> no overflow, count stays 16, 0x55 is read last.
//  4. rxErr and rxDone together with data 0x33, plus clearFlags in the same cycle ->
//     framingErr=1 and count unchanged; clearFlags next cycle -> framingErr=0.
//  5. Defaults, push 1 byte, then hold the line idle -> timeout pulses exactly once, 640 cycles after the push;
//     a new push rearms it for another 640 cycles.
//  6. UART_RX_ERRCNT_EN: 300 rxErr strobes -> errCount=255; clearFlags -> errCount=0.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Downstream byte stream from the UART receive controller: valid/ready handshake.
// The master side (the controller) drives the head byte and its valid flag.
interface uart_rx_ctrl_if;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;

    modport master (output outData, output outValid, input  outReady);
    modport slave  (input  outData, input  outValid, output outReady);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: FWFT byte FIFO, sticky error flags, character timeout.
// Optional error counter port enabled by defining UART_RX_ERRCNT_EN.
module uart_rx_ctrl #(
    parameter int unsigned Depth        = 16,
    parameter int unsigned Oversample   = 16,
    parameter int unsigned TimeoutChars = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rxData,
    input  logic                     rxDone,
    input  logic                     rxErr,
    input  logic                     enable,
    uart_rx_ctrl_if.master           out_if,
    output logic [$clog2(Depth):0]   count,
    output logic                     overflow,
    output logic                     framingErr,
    input  logic                     clearFlags,
    output logic                     timeout
`ifdef UART_RX_ERRCNT_EN
    ,
    output logic [7:0]               errCount
`endif
);

    localparam int unsigned PtrW          = $clog2(Depth);
    localparam int unsigned CntW          = PtrW + 1;
    localparam int unsigned TimeoutCycles = TimeoutChars * 10 * Oversample;
    localparam int unsigned TmrW          = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } tmr_state_e;

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            valid_q, valid_d;
    logic            overflow_q, overflow_d;
    logic            framing_q, framing_d;
    logic            timeout_q, timeout_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    tmr_state_e      state_q, state_d;

    logic push_req_c;
    logic pop_c;
    logic full_c;
    logic store_c;
    logic drop_c;

    // A push request while full is still stored if the head leaves in the same cycle.
    always_comb begin
        push_req_c = rxDone & enable & ~rxErr;
        pop_c      = valid_q & out_if.outReady;
        full_c     = (count_q == CntW'(Depth));
        store_c    = push_req_c & (~full_c | pop_c);
        drop_c     = push_req_c & full_c & ~pop_c;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        framing_d  = framing_q;

        if (store_c) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_c)   rd_ptr_d = rd_ptr_q + PtrW'(1);

        case ({store_c, pop_c})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CntW'(0));

        // Set events take priority over a same-cycle clear.
        overflow_d = drop_c | (overflow_q & ~clearFlags);
        framing_d  = rxErr  | (framing_q  & ~clearFlags);
    end

    // Character-timeout FSM; only receive activity restarts the idle count.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_d = TmrW'(0);
                if (store_c) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (count_d == CntW'(0)) begin
                    state_d = ST_IDLE;
                    tmr_d   = TmrW'(0);
                end else if (push_req_c) begin
                    tmr_d = TmrW'(0);
                end else if (tmr_q == TmrW'(TimeoutCycles - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FIRED;
                    tmr_d     = TmrW'(0);
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            ST_FIRED: begin
                tmr_d = TmrW'(0);
                if (count_d == CntW'(0)) begin
                    state_d = ST_IDLE;
                end else if (push_req_c) begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = TmrW'(0);
            end
        endcase
    end

`ifdef UART_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_inc_c;

    always_comb begin
        err_inc_c = rxErr | drop_c;
        err_cnt_d = err_cnt_q;
        if (clearFlags) begin
            err_cnt_d = err_inc_c ? 8'd1 : 8'd0;
        end else if (err_inc_c && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= 8'd0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign errCount = err_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            framing_q  <= 1'b0;
            timeout_q  <= 1'b0;
            tmr_q      <= '0;
            state_q    <= ST_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            framing_q  <= framing_d;
            timeout_q  <= timeout_d;
            tmr_q      <= tmr_d;
            state_q    <= state_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (store_c && !reset) mem_q[wr_ptr_q] <= rxData;
    end

    assign out_if.outData  = mem_q[rd_ptr_q];
    assign out_if.outValid = valid_q;
    assign count           = count_q;
    assign overflow        = overflow_q;
    assign framingErr      = framing_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: scoreboard of expected bytes, per-scenario tasks.
// Inputs change 1 time unit after the rising edge; outputs are checked there or on the falling edge.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxData;
    logic       rxDone;
    logic       rxErr;
    logic       enable;
    logic [4:0] count;
    logic       overflow;
    logic       framingErr;
    logic       clearFlags;
    logic       timeout;
`ifdef UART_RX_ERRCNT_EN
    logic [7:0] errCount;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_ctrl_if dut_if ();

    uart_rx_ctrl #(.Depth(16), .Oversample(16), .TimeoutChars(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxData     (rxData),
        .rxDone     (rxDone),
        .rxErr      (rxErr),
        .enable     (enable),
        .out_if     (dut_if),
        .count      (count),
        .overflow   (overflow),
        .framingErr (framingErr),
        .clearFlags (clearFlags),
        .timeout    (timeout)
`ifdef UART_RX_ERRCNT_EN
        ,
        .errCount   (errCount)
`endif
    );

    // Pop monitor: each accepted head byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && dut_if.outValid === 1'b1 && dut_if.outReady === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got %02h, expected no byte", dut_if.outData);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dut_if.outData !== e) begin
                    miscompares++;
                    $display("FAIL pop_data: got %02h, expected %02h", dut_if.outData, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_stored);
        rxData = b;
        rxDone = 1'b1;
        if (expect_stored) exp_q.push_back(b);
        tick();
        rxDone = 1'b0;
    endtask

    task automatic pulse_clear();
        clearFlags = 1'b1;
        tick();
        clearFlags = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        dut_if.outReady = 1'b1;
        for (i = 0; i < 40; i++) begin
            if (dut_if.outValid !== 1'b1) break;
            tick();
        end
        dut_if.outReady = 1'b0;
        vectors++;
        if (i == 40 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL %s_drain_count: got %0d, expected 0 within 40 cycles", name, count);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain_leftover: got %0d bytes still expected, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rxData = 8'h5A;
        rxDone = 1'b1;
        tick();
        tick();
        vectors++;
        if (count !== 5'd0 || dut_if.outValid !== 1'b0 || overflow !== 1'b0 ||
            framingErr !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got count=%0d valid=%b ovf=%b ferr=%b tmo=%b, expected all 0",
                     count, dut_if.outValid, overflow, framingErr, timeout);
        end
`ifdef UART_RX_ERRCNT_EN
        vectors++;
        if (errCount !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_errcount: got %0d, expected 0", errCount);
        end
`endif
        rxDone = 1'b0;
        reset  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_single();
        push(8'hA5, 1'b1);
        vectors++;
        if (dut_if.outValid !== 1'b1 || dut_if.outData !== 8'hA5 || count !== 5'd1) begin
            miscompares++;
            $display("FAIL single_push: got valid=%b data=%02h count=%0d, expected 1/a5/1",
                     dut_if.outValid, dut_if.outData, count);
        end
        tick();
        vectors++;
        if (count !== 5'd1) begin
            miscompares++;
            $display("FAIL single_hold: got count=%0d, expected 1 with outReady low", count);
        end
        drain("single");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        vectors++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_fill: got count=%0d ovf=%b, expected 16/0", count, overflow);
        end
        push(8'hFF, 1'b0);
        vectors++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drop: got count=%0d ovf=%b, expected 16/1", count, overflow);
        end
        drain("ovf");
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky: got %b, expected 1", overflow);
        end
        pulse_clear();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b, expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b1);
        dut_if.outReady = 1'b1;
        push(8'h55, 1'b1);
        dut_if.outReady = 1'b0;
        vectors++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pushpop: got count=%0d ovf=%b, expected 16/0", count, overflow);
        end
        drain("full_pushpop");
    endtask

    task automatic test_framing();
        pulse_clear();
        rxErr = 1'b1;
        clearFlags = 1'b1;
        push(8'h33, 1'b0);
        rxErr = 1'b0;
        clearFlags = 1'b0;
        vectors++;
        if (framingErr !== 1'b1 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL framing_set: got ferr=%b count=%0d, expected 1/0", framingErr, count);
        end
`ifdef UART_RX_ERRCNT_EN
        vectors++;
        if (errCount !== 8'd1) begin
            miscompares++;
            $display("FAIL framing_errcount: got %0d, expected 1", errCount);
        end
`endif
        pulse_clear();
        vectors++;
        if (framingErr !== 1'b0) begin
            miscompares++;
            $display("FAIL framing_clear: got %b, expected 0", framingErr);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        push(8'h77, 1'b0);
        vectors++;
        if (count !== 5'd0 || overflow !== 1'b0 || dut_if.outValid !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_discard: got count=%0d ovf=%b valid=%b, expected 0/0/0",
                     count, overflow, dut_if.outValid);
        end
        enable = 1'b1;
    endtask

    task automatic measure_timeout(output int first, output int pulses);
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= 700; k++) begin
            tick();
            if (timeout === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic test_timeout();
        int first, pulses;
        push(8'hC3, 1'b1);
        measure_timeout(first, pulses);
        vectors++;
        if (first != 640 || pulses != 1) begin
            miscompares++;
            $display("FAIL timeout_first: got at %0d x%0d, expected at 640 x1", first, pulses);
        end
        push(8'h3C, 1'b1);
        measure_timeout(first, pulses);
        vectors++;
        if (first != 640 || pulses != 1) begin
            miscompares++;
            $display("FAIL timeout_rearm: got at %0d x%0d, expected at 640 x1", first, pulses);
        end
        vectors++;
        if (count !== 5'd2) begin
            miscompares++;
            $display("FAIL timeout_count: got %0d, expected 2", count);
        end
        drain("timeout");
    endtask

    task automatic test_reset_mid();
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (count !== 5'd0 || dut_if.outValid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got count=%0d valid=%b, expected 0/0", count, dut_if.outValid);
        end
        push(8'h9A, 1'b1);
        vectors++;
        if (dut_if.outData !== 8'h9A || count !== 5'd1) begin
            miscompares++;
            $display("FAIL midreset_push: got data=%02h count=%0d, expected 9a/1", dut_if.outData, count);
        end
        drain("midreset");
    endtask

`ifdef UART_RX_ERRCNT_EN
    task automatic test_errcnt();
        rxErr = 1'b1;
        repeat (300) tick();
        rxErr = 1'b0;
        vectors++;
        if (errCount !== 8'd255) begin
            miscompares++;
            $display("FAIL errcnt_saturate: got %0d, expected 255", errCount);
        end
        pulse_clear();
        vectors++;
        if (errCount !== 8'd0) begin
            miscompares++;
            $display("FAIL errcnt_clear: got %0d, expected 0", errCount);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        rxData = 8'h00;
        rxDone = 1'b0;
        rxErr = 1'b0;
        enable = 1'b1;
        clearFlags = 1'b0;
        dut_if.outReady = 1'b0;
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_framing();
        test_enable();
        test_timeout();
        test_reset_mid();
`ifdef UART_RX_ERRCNT_EN
        test_errcnt();
`endif
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
